sd_cmd_phy: RTL and testbench

//  SD command-line PHY stage, directly downstream of the command layer. Takes a
//  40-bit command frame, appends CRC7 and end bit, and shifts it MSB-first onto
//  the CMD pin. It then releases the line, waits for the response start bit
//  (with timeout), shifts in a 48- or 136-bit response, and checks its CRC7.

---
 rtl/sd_cmd_phy_pkg.sv | 43 ++++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_cmd_phy.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_phy_pkg.sv
// rtl/sd_cmd_phy_pkg.sv - shared constants, state encoding and CRC7 step for the SD CMD PHY
package sd_cmd_phy_pkg;

    // Response lengths as presented by the command layer
    localparam logic [7:0] RSP_LEN_NONE  = 8'd0;
    localparam logic [7:0] RSP_LEN_SHORT = 8'd40;
    localparam logic [7:0] RSP_LEN_LONG  = 8'd136;

    // x^7 + x^3 + 1, top term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Bit positions, counted from the first bit of the frame = 0
    localparam logic [7:0] CMD_LAST_BIT      = 8'd39;
    localparam logic [7:0] CRC_LAST_BIT      = 8'd6;
    localparam logic [7:0] SHORT_LAST_BIT    = RSP_LEN_SHORT - 8'd1;
    localparam logic [7:0] LONG_CALC_FIRST   = 8'd8;
    localparam logic [7:0] LONG_CALC_LAST    = 8'd127;
    localparam logic [7:0] LONG_CRC_FIRST    = 8'd128;
    localparam logic [7:0] LONG_CRC_LAST     = 8'd134;
    localparam logic [7:0] LONG_LAST_BIT     = RSP_LEN_LONG - 8'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_CRC,
        ST_TX_END,
        ST_GAP,
        ST_TURN,
        ST_WAIT_START,
        ST_RX_RSP,
        ST_RX_CRC,
        ST_RX_END,
        ST_FINISHED
    } phy_state_t;

    // One serial CRC7 step, MSB-first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator, one bit per enable
module sd_crc7
    import sd_cmd_phy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    // Clear has priority so a new frame always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_crc <= 7'h00;
        end else if (i_clear) begin
            o_crc <= 7'h00;
        end else if (i_en) begin
            o_crc <= crc7_step(o_crc, i_bit);
        end
    end

endmodule

// File: rtl/sd_cmd_phy.sv
// rtl/sd_cmd_phy.sv - SD CMD line PHY: frame transmit with CRC7, response receive and check
module sd_cmd_phy
    import sd_cmd_phy_pkg::*;
#(
    parameter int NCC_GAP     = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_sd_stb,
    input  logic [15:0]  i_timeout,
    input  logic         i_cmd_en,
    input  logic [39:0]  i_cmd,
    input  logic [7:0]   i_cmd_len,
    input  logic [7:0]   i_rsp_len,
    output logic         o_rsp_finished_en,
    output logic [135:0] o_rsp,
    output logic         o_crc_bad,
    output logic         o_timeout,
    output logic         o_sd_cmd_dir,
    output logic         o_sd_cmd_out,
    input  logic         i_sd_cmd_in
);

    localparam logic [7:0] GAP_LAST  = 8'(NCC_GAP - 1);
    localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);

    phy_state_t  state, state_next;

    logic [39:0] tx_shift;
    logic [7:0]  rsp_len_q;
    logic [7:0]  bit_cnt;
    logic [15:0] tmo_cnt;
    logic [6:0]  rx_crc;
    logic [6:0]  tx_crc;
    logic [6:0]  rx_crc_calc;

    logic        abort;
    logic        rsp_none;
    logic        rsp_long;
    logic        crc_clear;
    logic        tx_crc_en;
    logic        rx_crc_en;
    logic        start_cmd;
    logic        cnt_clr;
    logic        cnt_one;
    logic        cnt_inc;
    logic        tmo_clr;
    logic        tmo_inc;
    logic        rsp_shift;
    logic        rx_crc_shift;
    logic        set_fin;
    logic        set_tmo;

    // Frames are always 40 bits before CRC; the length is carried for the command layer only
    logic        unused_cmd_len;
    assign unused_cmd_len = ^i_cmd_len;

    assign abort    = (state != ST_IDLE) && !i_cmd_en;
    assign rsp_none = (rsp_len_q == RSP_LEN_NONE);
    assign rsp_long = (rsp_len_q == RSP_LEN_LONG);

    sd_crc7 u_tx_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (crc_clear),
        .i_en    (tx_crc_en),
        .i_bit   (tx_shift[39]),
        .o_crc   (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (crc_clear),
        .i_en    (rx_crc_en),
        .i_bit   (i_sd_cmd_in),
        .o_crc   (rx_crc_calc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, pin drive and per-strobe datapath strobes
    always_comb begin
        state_next   = state;
        o_sd_cmd_dir = 1'b0;
        o_sd_cmd_out = 1'b1;
        crc_clear    = 1'b0;
        tx_crc_en    = 1'b0;
        rx_crc_en    = 1'b0;
        start_cmd    = 1'b0;
        cnt_clr      = 1'b0;
        cnt_one      = 1'b0;
        cnt_inc      = 1'b0;
        tmo_clr      = 1'b0;
        tmo_inc      = 1'b0;
        rsp_shift    = 1'b0;
        rx_crc_shift = 1'b0;
        set_fin      = 1'b0;
        set_tmo      = 1'b0;

        case (state)
            ST_IDLE: begin
                crc_clear = 1'b1;
                if (i_cmd_en) begin
                    start_cmd  = 1'b1;
                    state_next = ST_TX_CMD;
                end
            end

            ST_TX_CMD: begin
                o_sd_cmd_dir = 1'b1;
                o_sd_cmd_out = tx_shift[39];
                if (i_sd_stb) begin
                    tx_crc_en = 1'b1;
                    if (bit_cnt == CMD_LAST_BIT) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_TX_CRC;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_TX_CRC: begin
                o_sd_cmd_dir = 1'b1;
                o_sd_cmd_out = tx_crc[3'd6 - bit_cnt[2:0]];
                if (i_sd_stb) begin
                    if (bit_cnt == CRC_LAST_BIT) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_TX_END;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_TX_END: begin
                o_sd_cmd_dir = 1'b1;
                if (i_sd_stb) begin
                    cnt_clr    = 1'b1;
                    state_next = rsp_none ? ST_GAP : ST_TURN;
                end
            end

            ST_GAP: begin
                if (i_sd_stb) begin
                    if (bit_cnt == GAP_LAST) begin
                        set_fin    = 1'b1;
                        state_next = ST_FINISHED;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_TURN: begin
                if (i_sd_stb) begin
                    if (bit_cnt == TURN_LAST) begin
                        cnt_clr    = 1'b1;
                        tmo_clr    = 1'b1;
                        state_next = ST_WAIT_START;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_WAIT_START: begin
                if (i_sd_stb) begin
                    if (!i_sd_cmd_in) begin
                        // Start bit is response bit 0; long responses exclude it from CRC
                        rsp_shift  = 1'b1;
                        rx_crc_en  = !rsp_long;
                        cnt_one    = 1'b1;
                        state_next = ST_RX_RSP;
                    end else if ((i_timeout != 16'd0) && (tmo_cnt == i_timeout - 16'd1)) begin
                        set_tmo    = 1'b1;
                        set_fin    = 1'b1;
                        state_next = ST_FINISHED;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
            end

            ST_RX_RSP: begin
                if (i_sd_stb) begin
                    rsp_shift = 1'b1;
                    if (rsp_long) begin
                        rx_crc_en    = (bit_cnt >= LONG_CALC_FIRST) && (bit_cnt <= LONG_CALC_LAST);
                        rx_crc_shift = (bit_cnt >= LONG_CRC_FIRST) && (bit_cnt <= LONG_CRC_LAST);
                        if (bit_cnt == LONG_LAST_BIT) begin
                            set_fin    = 1'b1;
                            state_next = ST_FINISHED;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else begin
                        rx_crc_en = 1'b1;
                        if (bit_cnt == SHORT_LAST_BIT) begin
                            cnt_clr    = 1'b1;
                            state_next = ST_RX_CRC;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end

            ST_RX_CRC: begin
                if (i_sd_stb) begin
                    rx_crc_shift = 1'b1;
                    if (bit_cnt == CRC_LAST_BIT) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_RX_END;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_RX_END: begin
                if (i_sd_stb) begin
                    set_fin    = 1'b1;
                    state_next = ST_FINISHED;
                end
            end

            ST_FINISHED: begin
                state_next = ST_FINISHED;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Dropping the request anywhere outside IDLE releases the pin at once
        if (abort) begin
            state_next   = ST_IDLE;
            o_sd_cmd_dir = 1'b0;
            o_sd_cmd_out = 1'b1;
        end
    end

    // Frame latch, bit/timeout counters, response capture and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift          <= '0;
            rsp_len_q         <= RSP_LEN_NONE;
            bit_cnt           <= '0;
            tmo_cnt           <= '0;
            rx_crc            <= '0;
            o_rsp             <= '0;
            o_crc_bad         <= 1'b0;
            o_timeout         <= 1'b0;
            o_rsp_finished_en <= 1'b0;
        end else if (start_cmd) begin
            tx_shift          <= i_cmd;
            rsp_len_q         <= i_rsp_len;
            bit_cnt           <= '0;
            tmo_cnt           <= '0;
            rx_crc            <= '0;
            o_rsp             <= '0;
            o_crc_bad         <= 1'b0;
            o_timeout         <= 1'b0;
            o_rsp_finished_en <= 1'b0;
        end else if (abort) begin
            o_rsp_finished_en <= 1'b0;
        end else begin
            if (tx_crc_en) begin
                tx_shift <= {tx_shift[38:0], 1'b0};
            end
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (cnt_one) begin
                bit_cnt <= 8'd1;
            end else if (cnt_inc && (bit_cnt != 8'hFF)) begin
                bit_cnt <= bit_cnt + 8'd1;
            end
            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_inc && (tmo_cnt != 16'hFFFF)) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (rsp_shift) begin
                o_rsp <= {o_rsp[134:0], i_sd_cmd_in};
            end
            if (rx_crc_shift) begin
                rx_crc <= {rx_crc[5:0], i_sd_cmd_in};
            end
            if (set_tmo) begin
                o_timeout <= 1'b1;
                o_rsp     <= '0;
            end
            if (set_fin) begin
                o_rsp_finished_en <= 1'b1;
                o_crc_bad         <= !set_tmo && !rsp_none && (rx_crc != rx_crc_calc);
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb/tb_sd_cmd_phy.sv - self-checking bench for sd_cmd_phy with a card model and CRC reference
module tb_sd_cmd_phy;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_sd_stb = 1'b0;
    logic [15:0]  i_timeout = '0;
    logic         i_cmd_en = 1'b0;
    logic [39:0]  i_cmd = '0;
    logic [7:0]   i_cmd_len = 8'd40;
    logic [7:0]   i_rsp_len = '0;
    logic         o_rsp_finished_en;
    logic [135:0] o_rsp;
    logic         o_crc_bad;
    logic         o_timeout;
    logic         o_sd_cmd_dir;
    logic         o_sd_cmd_out;
    logic         i_sd_cmd_in = 1'b1;

    int errors = 0;
    int checks = 0;

    sd_cmd_phy #(.NCC_GAP(8), .TURN_CYCLES(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_sd_stb          (i_sd_stb),
        .i_timeout         (i_timeout),
        .i_cmd_en          (i_cmd_en),
        .i_cmd             (i_cmd),
        .i_cmd_len         (i_cmd_len),
        .i_rsp_len         (i_rsp_len),
        .o_rsp_finished_en (o_rsp_finished_en),
        .o_rsp             (o_rsp),
        .o_crc_bad         (o_crc_bad),
        .o_timeout         (o_timeout),
        .o_sd_cmd_dir      (o_sd_cmd_dir),
        .o_sd_cmd_out      (o_sd_cmd_out),
        .i_sd_cmd_in       (i_sd_cmd_in)
    );

    always #5 clk = ~clk;

    // SD strobe: one system clock in four
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 i_sd_stb = 1'b1;
            @(posedge clk);
            #1 i_sd_stb = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // CRC7 as polynomial remainder of msg * x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_div(input logic [135:0] msg, input int n);
        logic [7:0] r;
        logic       b;
        r = 8'h00;
        for (int i = 0; i < n + 7; i++) begin
            b = (i < n) ? msg[n - 1 - i] : 1'b0;
            r = {r[6:0], b};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // Drives one command and plays the card: frame starts 'delay' strobes into the start-bit search
    task automatic run_cmd(input logic [39:0] cmd, input logic [7:0] rlen, input logic [135:0] frame,
                           input int nbits, input int delay, input logic [15:0] tmo, input int budget,
                           output logic [47:0] pin, output int ntx, output int post, output bit done);
        int idx;
        pin  = '0;
        ntx  = 0;
        post = 0;
        done = 1'b0;
        @(negedge clk);
        i_cmd       = cmd;
        i_cmd_len   = 8'd40;
        i_rsp_len   = rlen;
        i_timeout   = tmo;
        i_sd_cmd_in = 1'b1;
        i_cmd_en    = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (o_rsp_finished_en) begin
                done = 1'b1;
                break;
            end
            if (i_sd_stb) begin
                if (o_sd_cmd_dir) begin
                    pin = {pin[46:0], o_sd_cmd_out};
                    ntx++;
                    i_sd_cmd_in = 1'b1;
                end else if (ntx > 0) begin
                    idx = post - 2 - delay;
                    i_sd_cmd_in = (idx >= 0 && idx < nbits) ? frame[nbits - 1 - idx] : 1'b1;
                    post++;
                end
            end
        end
        i_sd_cmd_in = 1'b1;
    endtask

    // One full transaction against expectations derived from the frame rules
    task automatic exercise(input string name, input logic [39:0] cmd, input logic [7:0] rlen,
                            input logic [135:0] frame, input int delay, input logic [15:0] tmo,
                            output logic [47:0] pin);
        int           nbits, ntx, post, exp_post;
        bit           done;
        logic [135:0] exp_rsp;
        logic         exp_bad, exp_tmo;
        logic [47:0]  exp_pin;
        nbits   = (rlen == 8'd136) ? 136 : ((rlen == 8'd40) ? 48 : 0);
        exp_pin = {cmd, crc7_div({96'b0, cmd}, 40), 1'b1};
        exp_rsp = '0;
        exp_bad = 1'b0;
        exp_tmo = 1'b0;
        if (nbits == 0) begin
            exp_post = 8;
        end else if (tmo != 16'd0 && delay >= int'(tmo)) begin
            exp_tmo  = 1'b1;
            exp_post = 2 + int'(tmo);
        end else begin
            exp_post = 2 + delay + nbits;
            if (nbits == 48) begin
                exp_rsp = {96'b0, frame[47:8]};
                exp_bad = (frame[7:1] != crc7_div(frame >> 8, 40));
            end else begin
                exp_rsp = frame;
                exp_bad = (frame[7:1] != crc7_div(frame >> 8, 120));
            end
        end
        run_cmd(cmd, rlen, frame, nbits, delay, tmo, 3000, pin, ntx, post, done);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s finish: got %0b expected 1", name, done); end
        checks++;
        if (ntx !== 48) begin errors++; $display("FAIL %s tx_bits: got %0d expected 48", name, ntx); end
        checks++;
        if (pin !== exp_pin) begin errors++; $display("FAIL %s pin: got %h expected %h", name, pin, exp_pin); end
        checks++;
        if (post !== exp_post) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, post, exp_post); end
        checks++;
        if (o_rsp !== exp_rsp) begin errors++; $display("FAIL %s rsp: got %h expected %h", name, o_rsp, exp_rsp); end
        checks++;
        if (o_crc_bad !== exp_bad) begin errors++; $display("FAIL %s crc_bad: got %0b expected %0b", name, o_crc_bad, exp_bad); end
        checks++;
        if (o_timeout !== exp_tmo) begin errors++; $display("FAIL %s timeout: got %0b expected %0b", name, o_timeout, exp_tmo); end
        @(negedge clk);
        i_cmd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (o_rsp_finished_en !== 1'b0) begin errors++; $display("FAIL %s finish_drop: got %0b expected 0", name, o_rsp_finished_en); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_rsp_finished_en !== 1'b0) begin errors++; $display("FAIL reset finished: got %0b expected 0", o_rsp_finished_en); end
        checks++;
        if (o_rsp !== 136'b0) begin errors++; $display("FAIL reset rsp: got %h expected 0", o_rsp); end
        checks++;
        if ({o_crc_bad, o_timeout} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b expected 00", {o_crc_bad, o_timeout}); end
        checks++;
        if ({o_sd_cmd_dir, o_sd_cmd_out} !== 2'b01) begin errors++; $display("FAIL reset pin: got %b expected 01", {o_sd_cmd_dir, o_sd_cmd_out}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cmd0();
        logic [47:0] pin;
        exercise("cmd0", 40'h40_0000_0000, 8'd0, '0, 0, 16'd0, pin);
        checks++;
        if (pin !== 48'h40_0000_0000_95) begin errors++; $display("FAIL cmd0 bytes: got %h expected 400000000095", pin); end
    endtask

    task automatic test_cmd8();
        logic [47:0]  pin;
        logic [135:0] frame;
        frame = {88'b0, 48'h08_0000_01AA_13};
        exercise("cmd8_ok", 40'h48_0000_01AA, 8'd40, frame, 3, 16'd0, pin);
        checks++;
        if (pin !== 48'h48_0000_01AA_87) begin errors++; $display("FAIL cmd8 bytes: got %h expected 48000001aa87", pin); end
        frame = {88'b0, 48'h08_0000_01AA_15};
        exercise("cmd8_badcrc", 40'h48_0000_01AA, 8'd40, frame, 1, 16'd0, pin);
        checks++;
        if (o_crc_bad !== 1'b1) begin errors++; $display("FAIL cmd8 bad crc flag: got %0b expected 1", o_crc_bad); end
    endtask

    task automatic test_timeout();
        logic [47:0]  pin;
        logic [135:0] frame;
        int           ntx, post;
        bit           done;
        exercise("timeout16", 40'h48_0000_01AA, 8'd40, '0, 100000, 16'd16, pin);
        frame = {88'b0, 48'h08_0000_01AA_13};
        exercise("start_at_expiry", 40'h48_0000_01AA, 8'd40, frame, 3, 16'd4, pin);
        exercise("start_after_expiry", 40'h48_0000_01AA, 8'd40, frame, 4, 16'd4, pin);
        run_cmd(40'h48_0000_01AA, 8'd40, '0, 0, 0, 16'd0, 800, pin, ntx, post, done);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL wait_forever: finished got %0b expected 0", done); end
        @(negedge clk);
        i_cmd_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rsp_finished_en, o_sd_cmd_dir, o_sd_cmd_out} !== 3'b001) begin
            errors++;
            $display("FAIL wait_forever release: got %b expected 001", {o_rsp_finished_en, o_sd_cmd_dir, o_sd_cmd_out});
        end
        @(negedge clk);
    endtask

    task automatic test_r2();
        logic [47:0]  pin;
        logic [127:0] rnd;
        logic [119:0] cid;
        logic [135:0] frame;
        rnd   = {$urandom, $urandom, $urandom, $urandom};
        cid   = rnd[119:0];
        frame = {8'h3F, cid, crc7_div({16'b0, cid}, 120), 1'b1};
        exercise("cmd2_r2", 40'h42_0000_0000, 8'd136, frame, 2, 16'd64, pin);
    endtask

    task automatic test_reset_mid_frame();
        logic [47:0] pin;
        int          n;
        bit          hit;
        n   = 0;
        hit = 1'b0;
        @(negedge clk);
        i_cmd     = 40'h40_0000_0000;
        i_rsp_len = 8'd0;
        i_cmd_en  = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (i_sd_stb && o_sd_cmd_dir) begin
                n++;
                if (n == 21) begin
                    hit = 1'b1;
                    break;
                end
            end
        end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL reset_mid reach bit20: got %0d bits expected 21", n); end
        rst_n    = 1'b0;
        i_cmd_en = 1'b0;
        #1;
        checks++;
        if ({o_sd_cmd_dir, o_sd_cmd_out} !== 2'b01) begin errors++; $display("FAIL reset_mid pin: got %b expected 01", {o_sd_cmd_dir, o_sd_cmd_out}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exercise("cmd0_after_reset", 40'h40_0000_0000, 8'd0, '0, 0, 16'd0, pin);
        checks++;
        if (pin !== 48'h40_0000_0000_95) begin errors++; $display("FAIL reset_mid bytes: got %h expected 400000000095", pin); end
    endtask

    task automatic test_abort();
        int n;
        n = 0;
        @(negedge clk);
        i_cmd     = 40'h48_0000_01AA;
        i_rsp_len = 8'd40;
        i_timeout = 16'd0;
        i_cmd_en  = 1'b1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (i_sd_stb && o_sd_cmd_dir) n++;
        end
        i_cmd_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rsp_finished_en, o_sd_cmd_dir, o_sd_cmd_out} !== 3'b001) begin
            errors++;
            $display("FAIL abort release: got %b expected 001", {o_rsp_finished_en, o_sd_cmd_dir, o_sd_cmd_out});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [47:0]  pin;
        logic [39:0]  cmd, content;
        logic [119:0] cid;
        logic [127:0] rnd;
        logic [6:0]   crc;
        logic [135:0] frame;
        logic [15:0]  tmo;
        int           kind, delay;
        for (int it = 0; it < 8; it++) begin
            cmd   = {2'b01, 6'($urandom_range(0, 63)), 32'($urandom)};
            kind  = $urandom_range(0, 2);
            delay = $urandom_range(0, 6);
            tmo   = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(delay + 1 + $urandom_range(0, 3));
            if (kind == 0) begin
                exercise("rand_none", cmd, 8'd0, '0, 0, 16'd0, pin);
            end else if (kind == 1) begin
                content = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
                crc     = crc7_div({96'b0, content}, 40);
                if ($urandom_range(0, 2) == 0) crc = crc ^ 7'(1 << $urandom_range(0, 6));
                frame   = {88'b0, content, crc, 1'b1};
                exercise("rand_short", cmd, 8'd40, frame, delay, tmo, pin);
            end else begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                cid = rnd[119:0];
                crc = crc7_div({16'b0, cid}, 120);
                if ($urandom_range(0, 2) == 0) crc = crc ^ 7'(1 << $urandom_range(0, 6));
                frame = {8'h3F, cid, crc, 1'b1};
                exercise("rand_long", cmd, 8'd136, frame, delay, tmo, pin);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_timeout();
        test_r2();
        test_reset_mid_frame();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
